// File: rtl/lcd_serial_tx.sv
// Avalon-MM slave that shifts 9-bit LCD frames (D/C + 8 data bits) out MSB-first
// with a generated serial clock and chip-select, replacing PIO bit-banging.
module lcd_serial_tx #(
  parameter int unsigned DIV_RESET = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        lcd_cs_n,
  output logic        lcd_scl,
  output logic        lcd_sda
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOW  = 2'd1,
    ST_HIGH = 2'd2,
    ST_HOLD = 2'd3
  } state_e;

  localparam logic [1:0] ADDR_TXDATA = 2'd0;
  localparam logic [1:0] ADDR_STATUS = 2'd1;
  localparam logic [1:0] ADDR_DIV    = 2'd2;

  state_e      state_q;
  logic [3:0]  idx_q;
  logic [7:0]  phase_q;
  logic [7:0]  dlat_q;
  logic [7:0]  div_q;
  logic [8:0]  shift_q;
  logic        ovr_q;
  logic        cs_n_q;
  logic        scl_q;
  logic        sda_q;

  logic        wr_en;
  logic        wr_tx;
  logic        wr_status;
  logic        wr_div;
  logic        busy;
  logic        phase_done;
  logic [7:0]  div_eff;
  logic        unused_wdata;

  // Bus: a write is taken on any edge where chipselect && !write_n; there are
  // no wait states, and reads are decoded combinationally from address.
  assign wr_en      = chipselect && !write_n;
  assign wr_tx      = wr_en && (address == ADDR_TXDATA);
  assign wr_status  = wr_en && (address == ADDR_STATUS);
  assign wr_div     = wr_en && (address == ADDR_DIV);

  assign busy       = (state_q != ST_IDLE);
  assign div_eff    = (div_q == 8'd0) ? 8'd1 : div_q;
  assign phase_done = (phase_q == (dlat_q - 8'd1));

  assign unused_wdata = ^writedata[31:9];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      idx_q   <= 4'd0;
      phase_q <= 8'd0;
      dlat_q  <= 8'd1;
      div_q   <= 8'(DIV_RESET);
      shift_q <= 9'd0;
      ovr_q   <= 1'b0;
      cs_n_q  <= 1'b1;
      scl_q   <= 1'b0;
      sda_q   <= 1'b1;
    end else begin
      if (wr_div) begin
        div_q <= writedata[7:0];
      end

      // An overrun on the same edge as a clear must leave OVR set.
      if (wr_tx && busy) begin
        ovr_q <= 1'b1;
      end else if (wr_status && writedata[1]) begin
        ovr_q <= 1'b0;
      end

      case (state_q)
        ST_IDLE: begin
          if (wr_tx) begin
            state_q <= ST_LOW;
            shift_q <= writedata[8:0];
            idx_q   <= 4'd8;
            phase_q <= 8'd0;
            dlat_q  <= div_eff;
            cs_n_q  <= 1'b0;
            scl_q   <= 1'b0;
            sda_q   <= writedata[8];
          end
        end

        ST_LOW: begin
          if (phase_done) begin
            phase_q <= 8'd0;
            state_q <= ST_HIGH;
            scl_q   <= 1'b1;
          end else begin
            phase_q <= phase_q + 8'd1;
          end
        end

        ST_HIGH: begin
          if (phase_done) begin
            phase_q <= 8'd0;
            scl_q   <= 1'b0;
            if (idx_q == 4'd0) begin
              state_q <= ST_HOLD;
              sda_q   <= 1'b1;
            end else begin
              // Next bit moves onto SDA together with the SCL falling edge.
              state_q <= ST_LOW;
              idx_q   <= idx_q - 4'd1;
              shift_q <= {shift_q[7:0], 1'b0};
              sda_q   <= shift_q[7];
            end
          end else begin
            phase_q <= phase_q + 8'd1;
          end
        end

        ST_HOLD: begin
          if (phase_done) begin
            phase_q <= 8'd0;
            state_q <= ST_IDLE;
            cs_n_q  <= 1'b1;
          end else begin
            phase_q <= phase_q + 8'd1;
          end
        end

        default: begin
          state_q <= ST_IDLE;
          cs_n_q  <= 1'b1;
          scl_q   <= 1'b0;
          sda_q   <= 1'b1;
        end
      endcase
    end
  end

  always_comb begin
    readdata = 32'd0;
    case (address)
      ADDR_STATUS: readdata = {30'd0, ovr_q, busy};
      ADDR_DIV:    readdata = {24'd0, div_q};
      default:     readdata = 32'd0;
    endcase
  end

  assign lcd_cs_n = cs_n_q;
  assign lcd_scl  = scl_q;
  assign lcd_sda  = sda_q;

endmodule

// File: tb/tb_lcd_serial_tx.sv
// Bench for lcd_serial_tx: bus-level stimulus with a register/timing model, and a
// pin monitor that checks every frame against an expected-frame queue.
module tb_lcd_serial_tx;

  localparam int DIV_RESET = 4;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  address = 2'd0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = 32'd0;
  logic [31:0] readdata;
  logic        lcd_cs_n;
  logic        lcd_scl;
  logic        lcd_sda;

  lcd_serial_tx #(.DIV_RESET(DIV_RESET)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .lcd_cs_n   (lcd_cs_n),
    .lcd_scl    (lcd_scl),
    .lcd_sda    (lcd_sda)
  );

  // ---------------- clock / cycle count ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_fail   = 0;

  // Entry: {effective divider D, 9-bit frame}
  logic [16:0] exp_q[$];

  logic [7:0] m_div = 8'(DIV_RESET);
  bit         m_ovr = 1'b0;
  bit         started = 1'b0;
  int         start_cyc = 0;
  int         cur_d = 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // A frame keeps BUSY high for 19*D cycles after its accepting edge.
  function automatic bit model_busy();
    return started && ((cyc - start_cyc) < 19 * cur_d);
  endfunction

  // ---------------- driver tasks ----------------
  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    bit busy_pre;
    int c;
    busy_pre = model_busy();
    c = cyc;
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    @(posedge clk);
    case (a)
      2'd0: begin
        if (busy_pre) m_ovr = 1'b1;
        else begin
          cur_d     = (m_div == 8'd0) ? 1 : int'(m_div);
          start_cyc = c + 1;
          started   = 1'b1;
          exp_q.push_back({8'(cur_d), d[8:0]});
        end
      end
      2'd1: if (d[1]) m_ovr = 1'b0;
      2'd2: m_div = d[7:0];
      default: ;
    endcase
    #1;
    chipselect = 1'b0; write_n = 1'b1; address = 2'd0; writedata = 32'd0;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
    address = a; chipselect = 1'b1; write_n = 1'b1;
    #1;
    d = readdata;
    chipselect = 1'b0; address = 2'd0;
  endtask

  task automatic check_status();
    logic [31:0] r;
    logic [31:0] e;
    e = {30'd0, m_ovr, model_busy()};
    bus_read(2'd1, r);
    check("status", r, e);
  endtask

  task automatic check_div();
    logic [31:0] r;
    bus_read(2'd2, r);
    check("div readback", r, {24'd0, m_div});
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_cyc(input int target);
    int k = 0;
    while (cyc < target && k < 2000) begin
      @(negedge clk);
      k++;
    end
    if (cyc != target) begin
      n_checks++; n_fail++;
      $display("FAIL wait_cyc: cycle %0d, required %0d", cyc, target);
    end
  endtask

  task automatic wait_idle(input int budget);
    int k = 0;
    while ((exp_q.size() != 0 || model_busy()) && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (k >= budget) begin
      n_checks++; n_fail++;
      $display("FAIL frame timeout: %0d frames outstanding after %0d cycles", exp_q.size(), budget);
      exp_q.delete();
      started = 1'b0;
    end
    @(negedge clk);
  endtask

  // ---------------- pin monitor ----------------
  bit          in_frame = 1'b0;
  bit          have_exp = 1'b0;
  bit          wave_ok = 1'b1;
  int          t = 0;
  int          nbits = 0;
  int          md = 1;
  int          bi = 0;
  int          idle_bad = 0;
  logic [8:0]  cap = 9'd0;
  logic [16:0] cur = 17'd0;
  logic [16:0] popped;
  logic        prev_scl = 1'b0;
  logic        exp_scl;
  logic        exp_sda;

  always @(negedge clk) begin
    if (!reset_n) begin
      in_frame = 1'b0;
    end else if (!lcd_cs_n) begin
      if (!in_frame) begin
        in_frame = 1'b1;
        t = 0; nbits = 0; cap = 9'd0; wave_ok = 1'b1;
        have_exp = (exp_q.size() != 0);
        cur = have_exp ? exp_q[0] : 17'd0;
        md = have_exp ? int'(cur[16:9]) : 1;
        if (md == 0) md = 1;
      end
      // Bits occupy 2*D sample slots (LOW then HIGH), then D slots of HOLD.
      if (t < 18 * md) begin
        bi = 8 - t / (2 * md);
        exp_scl = ((t / md) % 2) == 1;
        exp_sda = cur[bi];
      end else begin
        exp_scl = 1'b0;
        exp_sda = 1'b1;
      end
      if (lcd_scl !== exp_scl || lcd_sda !== exp_sda) wave_ok = 1'b0;
      if (lcd_scl && !prev_scl) begin
        cap = {cap[7:0], lcd_sda};
        nbits++;
      end
      t++;
    end else begin
      if (in_frame) begin
        in_frame = 1'b0;
        check("frame expected", 32'(have_exp), 32'd1);
        if (have_exp) begin
          popped = exp_q.pop_front();
          check("frame bits at scl rise", 32'(cap), 32'(popped[8:0]));
          check("scl rising edges", nbits, 9);
          check("cs_n low cycles", t, 19 * md);
          check("frame waveform", 32'(wave_ok), 32'd1);
        end
      end
      if (lcd_scl !== 1'b0 || lcd_sda !== 1'b1) idle_bad++;
    end
    prev_scl = lcd_scl;
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] r;
    int s;
    int nd;

    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset cs_n", 32'(lcd_cs_n), 32'd1);
    check("reset scl", 32'(lcd_scl), 32'd0);
    check("reset sda", 32'(lcd_sda), 32'd1);
    reset_n = 1'b1;
    @(negedge clk);
    check_status();
    check_div();

    // Basic frame, D=1
    bus_write(2'd2, 32'd1);
    bus_write(2'd0, 32'h1A5);
    check_status();
    bus_read(2'd0, r);
    check("txdata read", r, 32'd0);
    wait_idle(200);
    check_status();

    // Divider D=3
    bus_write(2'd2, 32'd3);
    check_div();
    bus_write(2'd0, 32'h0FF);
    check_status();
    wait_idle(300);
    check_status();

    // Overrun, D=2
    bus_write(2'd2, 32'd2);
    bus_write(2'd0, 32'h155);
    wait_cycles(5);
    bus_write(2'd0, 32'h0AA);
    check_status();
    bus_write(2'd1, 32'h2);
    check_status();
    wait_idle(200);
    check_status();

    // DIV=0 behaves as D=1; DIV write mid-frame affects only the next frame
    bus_write(2'd2, 32'd0);
    bus_write(2'd0, 32'h12C);
    wait_cycles(4);
    bus_write(2'd2, 32'd5);
    check_div();
    wait_idle(200);
    bus_write(2'd0, 32'h033);
    wait_idle(400);

    // Write on the final edge of a frame is an overrun; next edge is accepted
    bus_write(2'd2, 32'd1);
    bus_write(2'd0, 32'h0F0);
    s = start_cyc;
    wait_cyc(s + 18);
    bus_write(2'd0, 32'h111);
    bus_write(2'd0, 32'h1E1);
    check_status();
    bus_write(2'd1, 32'h2);
    wait_idle(200);
    check_status();

    // Reset during bit index 4 of a D=3 frame
    bus_write(2'd2, 32'd3);
    bus_write(2'd0, 32'h1C3);
    s = start_cyc;
    bus_write(2'd0, 32'h001);
    wait_cyc(s + 8 * 3 + 1);
    @(posedge clk);
    #2;
    check("cs_n before reset", 32'(lcd_cs_n), 32'd0);
    reset_n = 1'b0;
    exp_q.delete();
    started = 1'b0; m_ovr = 1'b0; m_div = 8'(DIV_RESET);
    #1;
    check("async reset cs_n", 32'(lcd_cs_n), 32'd1);
    check("async reset scl", 32'(lcd_scl), 32'd0);
    check("async reset sda", 32'(lcd_sda), 32'd1);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check_status();
    check_div();
    bus_write(2'd0, 32'h0C3);
    wait_idle(300);
    check_status();

    // Readback of unmapped/write-only locations and DIV upper bits
    bus_write(2'd3, 32'hFFFF_FFFF);
    bus_read(2'd3, r);
    check("addr3 read", r, 32'd0);
    bus_read(2'd0, r);
    check("addr0 read", r, 32'd0);
    bus_write(2'd2, 32'hFFFF_FFFF);
    bus_read(2'd2, r);
    check("div upper bits", r, 32'h0000_00FF);
    check_status();

    // Randomized frames with bus traffic during transmission
    bus_write(2'd2, 32'd2);
    for (int i = 0; i < 20; i++) begin
      if ($urandom_range(0, 2) == 0) begin
        bus_write(2'd2, 32'($urandom_range(0, 4)));
        check_div();
      end
      bus_write(2'd0, $urandom);
      nd = $urandom_range(0, 3);
      for (int j = 0; j < nd; j++) begin
        wait_cycles($urandom_range(0, 20));
        case ($urandom_range(0, 3))
          0:       bus_write(2'd0, $urandom);
          1:       bus_write(2'd1, $urandom);
          2:       bus_write(2'd2, 32'($urandom_range(0, 4)));
          default: check_status();
        endcase
      end
      wait_idle(400);
      check_status();
    end

    check("idle pin errors", 32'(idle_bad), 32'd0);
    check("frames left in queue", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    n_checks++; n_fail++;
    $display("FAIL watchdog: simulation did not finish in time");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "watchdog expired");
  end

endmodule
